if_id_buffer: RTL and testbench

Two-entry (parameterisable) instruction buffer between the fetch unit and the decode stage. Captures each fetched {PC, instruction} pair, presents it to decode with a valid/ready handshake, and back-pressures fetch by deasserting `in_ready`, which drives the PC register enable. A `flush` input discards all buffered entries on branch or jump redirects so wrong-path instructions never reach decode.

---
 rtl/if_id_pkg.sv | 13 +
 rtl/if_id_buffer.sv | 98 +++++++++
 tb/tb_if_id_buffer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_id_pkg.sv
// Shared fetch/decode packet definitions used by the IF/ID buffer, the decode
// stage and the fetch top level.
package if_id_pkg;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 16;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/if_id_buffer.sv
// IF/ID instruction FIFO: circular storage of fetch packets, valid/ready on both
// sides, flush on redirect. Define IF_ID_BYPASS_EN for 0-cycle empty-buffer bypass.
module if_id_buffer #(
  parameter int DEPTH   = 2,
  parameter int PC_W    = 10,
  parameter int INSTR_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [INSTR_W-1:0]         in_instr,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [PC_W-1:0]            out_pc,
  output logic [INSTR_W-1:0]         out_instr,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  import if_id_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_pkt_t mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             push, pop, stored_valid, bypass_hit;
  fetch_pkt_t       head_pkt, in_pkt, out_pkt;

  assign in_pkt       = {in_pc, in_instr};
  assign head_pkt     = mem[rd_ptr_reg];
  assign stored_valid = (count_reg != '0);
  assign in_ready     = (count_reg < FULL_CNT);

`ifdef IF_ID_BYPASS_EN
  // An empty buffer forwards the fetch packet straight through; if decode takes
  // it in the same cycle it is never written.
  assign bypass_hit = !stored_valid && in_valid && !flush && !reset;
  assign push       = in_valid && in_ready && !flush && !(bypass_hit && out_ready);
`else
  assign bypass_hit = 1'b0;
  assign push       = in_valid && in_ready && !flush;
`endif

  assign pop       = stored_valid && out_ready && !flush;
  assign out_valid = stored_valid || bypass_hit;
  assign count     = count_reg;

  always_comb begin
    out_pkt = '0;
    if (stored_valid)
      out_pkt = head_pkt;
    else if (bypass_hit)
      out_pkt = in_pkt;
  end

  assign out_pc    = out_pkt.pc;
  assign out_instr = out_pkt.instr;

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (push)
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    if (pop)
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Reset and flush leave the same empty state; storage contents stay stale.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= in_pkt;
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Randomised and directed bench for if_id_buffer against a queue-based FIFO model.
module tb_if_id_buffer;
  import if_id_pkg::*;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH+1);
`ifdef IF_ID_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset, in_valid, flush, out_ready;
  logic               in_ready, out_valid;
  logic [PC_W-1:0]    in_pc, out_pc;
  logic [INSTR_W-1:0] in_instr, out_instr;
  logic [CW-1:0]      count;

  always #5 clk = ~clk;

  if_id_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr(in_instr), .in_ready(in_ready), .flush(flush),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready), .count(count)
  );

  typedef struct packed {
    logic [CW-1:0]      count;
    logic               in_ready;
    logic               out_valid;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } obs_t;

  fetch_pkt_t mq[$];
  int         checks = 0;
  int         errors = 0;
  obs_t       got, exp_o;
  bit         acc, popped;
  fetch_pkt_t ppkt;

  function automatic obs_t observe();
    obs_t o;
    o.count = count; o.in_ready = in_ready; o.out_valid = out_valid;
    o.pc = out_pc; o.instr = out_instr;
    return o;
  endfunction

  // Expected outputs from the FIFO contents and current inputs.
  function automatic obs_t model_obs();
    obs_t o;
    bit   b;
    b = BYP && mq.size() == 0 && in_valid && !flush && !reset;
    o.count     = CW'(mq.size());
    o.in_ready  = (mq.size() < DEPTH);
    o.out_valid = (mq.size() != 0) || b;
    o.pc        = '0;
    o.instr     = '0;
    if (mq.size() != 0) begin
      o.pc = mq[0].pc; o.instr = mq[0].instr;
    end else if (b) begin
      o.pc = in_pc; o.instr = in_instr;
    end
    return o;
  endfunction

  task automatic apply(input logic iv, input logic [PC_W-1:0] pc,
                       input logic [INSTR_W-1:0] ins, input logic ordy,
                       input logic fl, input logic rst);
    in_valid = iv; in_pc = pc; in_instr = ins;
    out_ready = ordy; flush = fl; reset = rst;
    #1;
  endtask

  // Advance one clock, updating the model queue from the applied inputs.
  task automatic step(output bit a, output bit p, output fetch_pkt_t k);
    bit full, b, do_pop, do_push;
    full    = mq.size() >= DEPTH;
    b       = BYP && mq.size() == 0 && in_valid && !flush && !reset;
    do_pop  = mq.size() != 0 && out_ready;
    do_push = in_valid && !full && !(b && out_ready);
    a       = in_valid && !full && !flush && !reset;
    p       = (do_pop || (b && out_ready)) && !flush && !reset;
    k       = {in_pc, in_instr};
    if (do_pop) k = mq[0];
    @(posedge clk);
    if (reset || flush) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({in_pc, in_instr});
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply(1'b1, 10'h3ff, 16'hbeef, 1'b0, 1'b0, 1'b1);
    step(acc, popped, ppkt);
    step(acc, popped, ppkt);
    got = observe(); exp_o = model_obs(); checks++;
    if (got !== exp_o) begin
      errors++;
      $display("FAIL reset actual=%h expected=%h", got, exp_o);
    end
    checks++;
    if (got !== obs_t'({CW'(0), 1'b1, 1'b0, PC_W'(0), INSTR_W'(0)})) begin
      errors++;
      $display("FAIL reset_const actual=%h expected=count0,in_ready1,empty", got);
    end
    apply(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    step(acc, popped, ppkt);
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 5; i++) begin
      apply(i < 4, PC_W'(i), INSTR_W'(16'h1000 + i), 1'b1, 1'b0, 1'b0);
      got = observe(); exp_o = model_obs(); checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL streaming cyc=%0d actual=%h expected=%h", i, got, exp_o);
      end
      checks++;
      if (count > CW'(1)) begin
        errors++;
        $display("FAIL streaming_count cyc=%0d actual=%0d expected<=1", i, count);
      end
      step(acc, popped, ppkt);
    end
  endtask

  task automatic test_back_pressure();
    bit done7 = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 3)
        apply(1'b1, PC_W'(5 + i), INSTR_W'(16'h1005 + i), 1'b0, 1'b0, 1'b0);
      else
        apply(!done7, 10'd7, 16'h1007, 1'b1, 1'b0, 1'b0);
      got = observe(); exp_o = model_obs(); checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL back_pressure cyc=%0d actual=%h expected=%h", i, got, exp_o);
      end
      step(acc, popped, ppkt);
      if (i >= 2 && acc && in_pc == 10'd7) done7 = 1;
    end
    checks++;
    if (!done7 || count !== CW'(0)) begin
      errors++;
      $display("FAIL back_pressure_done actual=accepted%0d,count%0d expected=accepted1,count0", done7, count);
    end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: apply(1'b1, 10'd30, 16'h1030, 1'b0, 1'b0, 1'b0);
        1: apply(1'b1, 10'd31, 16'h1031, 1'b0, 1'b0, 1'b0);
        2: apply(1'b1, 10'd50, 16'h1050, 1'b1, 1'b0, 1'b0);
        3: apply(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        default: apply(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      endcase
      got = observe(); exp_o = model_obs(); checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL full_pop cyc=%0d actual=%h expected=%h", i, got, exp_o);
      end
      step(acc, popped, ppkt);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: apply(1'b1, 10'd40, 16'h1040, 1'b0, 1'b0, 1'b0);
        1: apply(1'b1, 10'd41, 16'h1041, 1'b0, 1'b0, 1'b0);
        2: apply(1'b1, 10'd100, 16'h1100, 1'b0, 1'b1, 1'b0);
        3: apply(1'b1, 10'd100, 16'h1100, 1'b0, 1'b0, 1'b0);
        default: apply(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      endcase
      got = observe(); exp_o = model_obs(); checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL flush cyc=%0d actual=%h expected=%h", i, got, exp_o);
      end
      step(acc, popped, ppkt);
    end
  endtask

  task automatic test_wrap();
    logic [PC_W-1:0] order[$];
    int pushed = 0;
    int cyc = 0;
    while ((pushed < 9 || order.size() != 0) && cyc < 80) begin
      apply(pushed < 9, PC_W'(200 + pushed), INSTR_W'(16'h2000 + pushed),
            1'(cyc % 2), 1'b0, 1'b0);
      got = observe(); exp_o = model_obs(); checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL wrap cyc=%0d actual=%h expected=%h", cyc, got, exp_o);
      end
      step(acc, popped, ppkt);
      if (acc) begin order.push_back(in_pc); pushed++; end
      if (popped) begin
        checks++;
        if (order.size() == 0 || ppkt.pc !== order[0]) begin
          errors++;
          $display("FAIL wrap_order cyc=%0d actual=%0d expected=%0d", cyc, ppkt.pc,
                   order.size() ? order[0] : PC_W'(0));
        end
        if (order.size() != 0) void'(order.pop_front());
      end
      cyc++;
    end
    checks++;
    if (cyc >= 80) begin
      errors++;
      $display("FAIL wrap_timeout actual=%0d cycles expected<80", cyc);
    end
`ifdef IF_ID_BYPASS_EN
    apply(1'b1, 10'd300, 16'h3300, 1'b1, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 10'd300 || out_instr !== 16'h3300) begin
      errors++;
      $display("FAIL bypass actual=%b/%0d/%h expected=1/300/3300", out_valid, out_pc, out_instr);
    end
    step(acc, popped, ppkt);
    apply(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (count !== CW'(0)) begin
      errors++;
      $display("FAIL bypass_count actual=%0d expected=0", count);
    end
    step(acc, popped, ppkt);
`endif
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0, 1: apply(1'b1, PC_W'(60 + i), INSTR_W'(16'h1060 + i), 1'b0, 1'b0, 1'b0);
        2: apply(1'b1, 10'd62, 16'h1062, 1'b1, 1'b0, 1'b1);
        default: apply(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      endcase
      got = observe(); exp_o = model_obs(); checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL reset_mid cyc=%0d actual=%h expected=%h", i, got, exp_o);
      end
      step(acc, popped, ppkt);
    end
  endtask

  task automatic test_random();
    logic [PC_W-1:0]    pc_h = '0;
    logic [INSTR_W-1:0] ins_h = '0;
    bit pend = 0;
    bit iv, fl, rst, ordy;
    for (int c = 0; c < 400; c++) begin
      iv = pend ? 1'b1 : ($urandom_range(9) < 7);
      if (!pend) begin
        pc_h  = PC_W'($urandom);
        ins_h = INSTR_W'($urandom);
      end
      fl   = ($urandom_range(19) == 0);
      rst  = ($urandom_range(39) == 0);
      ordy = ($urandom_range(9) < 6);
      apply(iv, pc_h, ins_h, ordy, fl, rst);
      got = observe(); exp_o = model_obs(); checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL random cyc=%0d actual=%h expected=%h", c, got, exp_o);
      end
      step(acc, popped, ppkt);
      pend = iv && !acc && !fl && !rst;
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_full_pop();
    test_flush();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
